// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared fetch-path widths, reset vector and address type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int unsigned        DEFAULT_XLEN         = 32;
    localparam logic [31:0]        DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef logic [DEFAULT_XLEN-1:0] addr_t;

    localparam addr_t INSN_BYTES = addr_t'(4);

endpackage

`default_nettype wire

// File: rtl/pc_plus_4.sv
// ============================================================================
// Module   : pc_plus_4
// Brief    : Sequential-successor adder; wraps modulo 2^XLEN, no carry-out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_plus_4
    import cpu_pkg::*;
(
    input  addr_t pc_in,
    output addr_t pc_out
);

    assign pc_out = pc_in + INSN_BYTES;

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
// ============================================================================
// Module   : pc_unit
// Brief    : Program-counter register with sequential/external next-PC select.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_unit
    import cpu_pkg::*;
#(
    parameter int unsigned          XLEN         = DEFAULT_XLEN,
    parameter logic [XLEN-1:0]      RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            pc_sel,
    input  logic [XLEN-1:0] pc_in,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus_4_out,
    output logic            misaligned
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    addr_t           w_pc_seq;

    pc_plus_4 u_pc_plus_4 (
        .pc_in  (pc_q),
        .pc_out (w_pc_seq)
    );

    // Stall wins over both mux legs, so pc_in is never sampled while holding.
    always_comb begin
        pc_d = pc_q;
        if (!stall) begin
            pc_d = pc_sel ? w_pc_seq : pc_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_out        = pc_q;
    assign pc_plus_4_out = w_pc_seq;
    assign misaligned    = |pc_q[1:0];

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// ============================================================================
// Module   : tb_pc_unit
// Brief    : Directed self-checking bench for pc_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        pc_sel;
    logic [31:0] pc_in;
    logic [31:0] pc_out;
    logic [31:0] pc_plus_4_out;
    logic        misaligned;

    int checks   = 0;
    int failures = 0;

    pc_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .pc_sel        (pc_sel),
        .pc_in         (pc_in),
        .pc_out        (pc_out),
        .pc_plus_4_out (pc_plus_4_out),
        .misaligned    (misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b1;
        stall  = 1'b1;
        pc_sel = 1'b0;
        pc_in  = 32'h0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pc_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_pc: got %h expected %h", pc_out, 32'h0);
        end
        checks++;
        if (pc_plus_4_out !== 32'h4) begin
            failures++;
            $display("FAIL reset_plus4: got %h expected %h", pc_plus_4_out, 32'h4);
        end
        checks++;
        if (misaligned !== 1'b0) begin
            failures++;
            $display("FAIL reset_misaligned: got %b expected 0", misaligned);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (pc_out !== 32'h0) begin
            failures++;
            $display("FAIL release_no_edge: got %h expected %h", pc_out, 32'h0);
        end
    endtask

    task automatic test_load();
        stall  = 1'b0;
        pc_sel = 1'b0;
        pc_in  = 32'h4;
        #1;
        checks++;
        if (pc_out !== 32'h0) begin
            failures++;
            $display("FAIL no_bypass: got %h expected %h", pc_out, 32'h0);
        end
        step();
        checks++;
        if (pc_out !== 32'h4 || pc_plus_4_out !== 32'h8) begin
            failures++;
            $display("FAIL load_4: got pc=%h p4=%h expected pc=4 p4=8", pc_out, pc_plus_4_out);
        end
        pc_in = 32'h8;
        step();
        checks++;
        if (pc_out !== 32'h8 || pc_plus_4_out !== 32'hC) begin
            failures++;
            $display("FAIL load_8: got pc=%h p4=%h expected pc=8 p4=c", pc_out, pc_plus_4_out);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_seq [3] = '{32'd12, 32'd16, 32'd20};
        pc_sel = 1'b1;
        pc_in  = 32'hDEAD_BEE0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (pc_out !== exp_seq[i]) begin
                failures++;
                $display("FAIL seq_%0d: got %h expected %h", i, pc_out, exp_seq[i]);
            end
        end
    endtask

    task automatic test_stall();
        stall  = 1'b1;
        pc_sel = 1'b0;
        pc_in  = 32'd100;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (pc_out !== 32'd20) begin
                failures++;
                $display("FAIL stall_%0d: got %h expected %h", i, pc_out, 32'd20);
            end
        end
        pc_sel = 1'b1;
        step();
        checks++;
        if (pc_out !== 32'd20) begin
            failures++;
            $display("FAIL stall_over_sel: got %h expected %h", pc_out, 32'd20);
        end
        stall = 1'b0;
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pc_out !== 32'h0) begin
            failures++;
            $display("FAIL async_reset: got %h expected %h", pc_out, 32'h0);
        end
        pc_sel = 1'b0;
        pc_in  = 32'd40;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (pc_out !== 32'h0) begin
                failures++;
                $display("FAIL reset_hold_%0d: got %h expected %h", i, pc_out, 32'h0);
            end
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (pc_out !== 32'd40) begin
            failures++;
            $display("FAIL post_reset_load: got %h expected %h", pc_out, 32'd40);
        end
    endtask

    task automatic test_wrap();
        pc_sel = 1'b0;
        pc_in  = 32'hFFFF_FFFC;
        step();
        checks++;
        if (pc_out !== 32'hFFFF_FFFC || pc_plus_4_out !== 32'h0) begin
            failures++;
            $display("FAIL wrap_load: got pc=%h p4=%h expected pc=fffffffc p4=0", pc_out, pc_plus_4_out);
        end
        pc_sel = 1'b1;
        step();
        checks++;
        if (pc_out !== 32'h0 || pc_plus_4_out !== 32'h4) begin
            failures++;
            $display("FAIL wrap_seq: got pc=%h p4=%h expected pc=0 p4=4", pc_out, pc_plus_4_out);
        end
        pc_sel = 1'b0;
        pc_in  = 32'hFFFF_FFFE;
        step();
        checks++;
        if (pc_plus_4_out !== 32'h2 || misaligned !== 1'b1) begin
            failures++;
            $display("FAIL wrap_odd: got p4=%h mis=%b expected p4=2 mis=1", pc_plus_4_out, misaligned);
        end
    endtask

    task automatic test_misaligned();
        pc_sel = 1'b0;
        pc_in  = 32'h0000_0006;
        step();
        checks++;
        if (pc_out !== 32'h6 || misaligned !== 1'b1 || pc_plus_4_out !== 32'hA) begin
            failures++;
            $display("FAIL misaligned_6: got pc=%h mis=%b p4=%h expected pc=6 mis=1 p4=a",
                     pc_out, misaligned, pc_plus_4_out);
        end
        pc_in = 32'h0000_0001;
        step();
        checks++;
        if (pc_out !== 32'h1 || misaligned !== 1'b1) begin
            failures++;
            $display("FAIL misaligned_1: got pc=%h mis=%b expected pc=1 mis=1", pc_out, misaligned);
        end
        pc_in = 32'h0000_0010;
        step();
        checks++;
        if (misaligned !== 1'b0) begin
            failures++;
            $display("FAIL aligned_10: got mis=%b expected 0", misaligned);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_sequential();
        test_stall();
        test_async_reset();
        test_wrap();
        test_misaligned();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter stage of the single-cycle CPU fetch path.
- Holds the current instruction address in a clocked register (pc) and computes the sequential successor address combinationally (pc_plus_4).
- Selects the next PC from the external next-PC input or the sequential address.
- Feeds instruction memory and the branch/jump logic.

Parameters:
- XLEN, 32, datapath/address width in bits.
- RESET_VECTOR, 32'h0000_0000, value loaded into the PC on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  1 = hold PC (no update this edge).
- pc_sel  input  1  0 = next PC is pc_in; 1 = next PC is the sequential address pc_out+4.
- pc_in  input  XLEN  externally computed next PC (branch/jump target or other).
- pc_out  output  XLEN  current PC, registered.
- pc_plus_4_out  output  XLEN  pc_out + 4, combinational.
- misaligned  output  1  1 when pc_out[1:0] != 2'b00.

Behaviour:
- Reset: rst_n low asynchronously forces pc_out = RESET_VECTOR, regardless of clk.
  - pc_plus_4_out then reads RESET_VECTOR+4.
  - misaligned reads 0 for the default vector.
- Release: PC updates on the first rising clk edge with rst_n high.
- Each rising edge with rst_n=1 and stall=0:
  - pc_sel=0: pc_out <= pc_in.
  - pc_sel=1: pc_out <= pc_out + 4.
- stall=1: pc_out holds; stall overrides pc_sel and pc_in.
- Latency: pc_in is visible on pc_out one edge after capture. No bypass; pc_out never reflects pc_in combinationally.
- pc_plus_4_out:
  - Pure combinational function of pc_out, zero latency.
  - Modulo 2^XLEN: 32'hFFFF_FFFC+4 = 0; 32'hFFFF_FFFE+4 = 32'h0000_0002.
  - No carry-out, no saturation.
- misaligned:
  - Combinational from pc_out[1:0].
  - Informational only; the PC loads any value including misaligned ones (no masking).
- Reset asserted mid-cycle: immediate return to RESET_VECTOR; a concurrent clock edge is ignored while rst_n=0.
- No X propagation from unused inputs: when stall=1 or pc_sel=1, pc_in is don't-care.

Decomposition:
- Shared package cpu_pkg:
  - XLEN default.
  - RESET_VECTOR default.
  - Constant INSN_BYTES = 4.
  - Typedef addr_t = logic [XLEN-1:0].
- Sub-module pc_plus_4:
  - Ports pc_in (addr_t) -> pc_out (addr_t).
  - Combinational adder of INSN_BYTES.
  - Instantiated once, driven by the PC register.
  - Its output feeds both pc_plus_4_out and the pc_sel=1 mux leg.
- PC register inline in pc_unit (a pc sub-module with clk, pc_in, pc_out is acceptable).

Test Plan:
- Reset: rst_n=0 between edges -> pc_out=0 immediately, pc_plus_4_out=4, misaligned=0. Release rst_n, no edge -> pc_out stays 0.
- Load: pc_sel=0, stall=0, pc_in=4, rising edge -> pc_out=4, pc_plus_4_out=8. Then pc_in=8, edge -> pc_out=8, pc_plus_4_out=12.
- Sequential/stall:
  - From pc_out=8, pc_sel=1 for 3 edges -> 12, 16, 20.
  - stall=1 for 2 edges with pc_in=100 -> pc_out stays 20.
- Wrap-around: load 32'hFFFF_FFFC, pc_plus_4_out=0. pc_sel=1, edge -> pc_out=0.
- Misaligned: load pc_in=32'h0000_0006 -> pc_out=6, misaligned=1, pc_plus_4_out=10.
- Async reset mid-run: pc_out=20, drop rst_n between edges -> pc_out=0 without a clock edge. Edges while rst_n=0 with pc_in=40 -> pc_out stays 0.
